// File: rtl/positadd_stream_es3.sv
// -----------------------------------------------------------------------------
// positadd_stream_es3
//
// Streaming front end for a fixed-latency es3 posit adder. Operand pairs are
// accepted on a valid/ready port, issued to the external adder, and the sums
// are collected in a show-ahead result FIFO. The FIFO is drained on a second
// valid/ready port.
//
// Credit scheme: a pair is accepted only when the registered FIFO occupancy
// plus the number of adds still in flight is below DEPTH. Every issued add
// therefore already owns a FIFO slot when its result returns. The adder has no
// stall input, so this is the only safe form of flow control.
//
// After reset the block sits in FLUSH for LATENCY+1 cycles. The adder pipeline
// is not reset, so results from adds issued before reset can still come out.
// They are discarded during FLUSH.
//
// Handshake semantics (both ports): a transfer happens in the cycle in which
// valid and ready are both high at the rising clock edge. valid never waits
// for ready. s_ready is computed from registered state only. m_valid reflects
// the registered FIFO count only.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   s_valid/s_ready     operand pair handshake; s_in1, s_in2 posit operands
//   add_start           issue strobe to the adder (= s_valid & s_ready)
//   add_in1/add_in2     adder operands, zero when not issuing
//   add_result/add_inf/add_zero/add_done
//                       adder sum, NaR flag, zero flag, result strobe
//   m_valid/m_ready     result handshake; m_result, m_inf, m_zero head entry
//   err_unexpected      sticky: add_done with nothing in flight, or add_done
//                       into a full FIFO with no pop in that cycle
//   dbg_state_o         current FSM state (0 = FLUSH, 1 = RUN)
// -----------------------------------------------------------------------------
module positadd_stream_es3 #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  // operand stream
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_in1,
  input  logic [31:0] s_in2,
  // adder interface
  output logic        add_start,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  input  logic [31:0] add_result,
  input  logic        add_inf,
  input  logic        add_zero,
  input  logic        add_done,
  // result stream
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_result,
  output logic        m_inf,
  output logic        m_zero,
  // status
  output logic        err_unexpected,
  output logic        dbg_state_o
);

  // Pointer width, count width (one extra bit so "full" is representable),
  // and occupancy sum width (one more bit so count+inflight cannot overflow).
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int LW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [LW-1:0] LAT_C   = LW'(LATENCY);

  // FIFO entry layout: {result[31:0], inf, zero}
  localparam int EW = 34;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [LW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;

  logic [EW-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  logic            run;
  logic [SW-1:0]   occupancy;
  logic            pop;
  logic            done_run;
  logic            fifo_full;
  logic            done_orphan;   // add_done with nothing in flight
  logic            done_overrun;  // add_done into a full FIFO, no pop
  logic            push;
  logic            retire;        // an in-flight add has returned
  logic [EW-1:0]   head;

  assign run       = (state_q == ST_RUN);
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};

  // reset gates the ready/valid outputs so they are low from the first reset
  // cycle, before the registered state has been cleared.
  assign s_ready   = run & ~reset & (occupancy < DEPTH_S);
  assign add_start = s_valid & s_ready;
  assign add_in1   = add_start ? s_in1 : 32'd0;
  assign add_in2   = add_start ? s_in2 : 32'd0;

  assign m_valid   = ~reset & (count_q != '0);
  assign pop       = m_valid & m_ready;

  assign done_run     = add_done & run & ~reset;
  assign fifo_full    = (count_q == DEPTH_C);
  assign done_orphan  = done_run & (inflight_q == '0);
  assign done_overrun = done_run & fifo_full & ~pop;

  // An orphan result has no credit and is never queued. An overrun result has
  // no slot and is dropped. Every other result in RUN is written.
  assign retire = done_run & ~done_orphan;
  assign push   = retire & ~done_overrun;

  assign head     = mem[rd_ptr_q];
  assign m_result = head[33:2];
  assign m_inf    = head[1];
  assign m_zero   = head[0];

  assign err_unexpected = err_q;
  assign dbg_state_o    = state_q;

  // ---------------------------------------------------------------------------
  // FSM next state: FLUSH counts down from LATENCY, then moves to RUN on the
  // cycle after the counter reads zero. This gives LATENCY+1 FLUSH cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - LW'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Credit, FIFO pointer and error next state
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q | done_orphan | done_overrun;

    unique case ({add_start, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    // Simultaneous push and pop leaves the count unchanged. This holds even
    // when the FIFO is full, because the pop frees the slot being written.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= LAT_C;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
    end
  end

  // Storage is not reset. Entries are only ever read when count_q says they
  // hold data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {add_result, add_inf, add_zero};
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants of the credit scheme
  // ---------------------------------------------------------------------------
  a_occupancy_bound: assert property (@(posedge clk) disable iff (reset)
    occupancy <= DEPTH_S);
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= DEPTH_C);
  a_no_issue_in_flush: assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_FLUSH) |-> !add_start);

endmodule

// File: tb/tb_positadd_stream_es3.sv
module tb_positadd_stream_es3;

  localparam int LAT = 4;
  localparam int DEP = 8;
  localparam logic [31:0] NAR = 32'h8000_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_valid, s_ready;
  logic [31:0] s_in1, s_in2;
  logic        add_start;
  logic [31:0] add_in1, add_in2, add_result;
  logic        add_inf, add_zero, add_done;
  logic        m_valid, m_ready;
  logic [31:0] m_result;
  logic        m_inf, m_zero;
  logic        err_unexpected;
  logic        dbg_state_o;

  positadd_stream_es3 #(.DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_in1          (s_in1),
    .s_in2          (s_in2),
    .add_start      (add_start),
    .add_in1        (add_in1),
    .add_in2        (add_in2),
    .add_result     (add_result),
    .add_inf        (add_inf),
    .add_zero       (add_zero),
    .add_done       (add_done),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_result       (m_result),
    .m_inf          (m_inf),
    .m_zero         (m_zero),
    .err_unexpected (err_unexpected),
    .dbg_state_o    (dbg_state_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Stub adder: fixed LATENCY pipeline, never reset. Known posit vectors give
  // their true sums; other operands give a deterministic stand-in value.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    if (a == 32'd0) return b;
    if (b == 32'd0) return a;
    if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4400_0000;
    return a + b;
  endfunction

  logic [LAT-1:0] pv = '0;
  logic [31:0]    pa [LAT];
  logic [31:0]    pb [LAT];
  logic           inject = 1'b0;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], add_start};
    pa[0] <= add_in1;
    pb[0] <= add_in2;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end

  assign add_result = stub_sum(pa[LAT-1], pb[LAT-1]);
  assign add_inf    = (add_result == NAR);
  assign add_zero   = (add_result == 32'd0);
  assign add_done   = pv[LAT-1] | inject;

  // ---------------------------------------------------------------------------
  // Scoreboard: expected entries pushed at handshake, popped at result
  // ---------------------------------------------------------------------------
  logic [33:0] exp_q[$];
  int          hs_cyc[$];
  int          pop_cyc[$];
  int          pop_count = 0;
  logic [31:0] sb_r;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      pop_count++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
      else check("sb_data", {m_result, m_inf, m_zero}, exp_q.pop_front());
    end
    if (s_valid && s_ready && !reset) begin
      sb_r = stub_sum(s_in1, s_in2);
      exp_q.push_back({sb_r, sb_r == NAR, sb_r == 32'd0});
      hs_cyc.push_back(cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called aligned to posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
    int waited = 0;
    s_valid = 1'b1;
    s_in1   = a;
    s_in2   = b;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready) check("drive_timeout", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Count cycles with s_ready low, starting in the first cycle after reset.
  task automatic count_flush(output int n);
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res,
                            input logic inf, input logic zero);
    int w = 0;
    @(negedge clk);
    while (!m_valid && w < 100) begin
      w++;
      @(negedge clk);
    end
    check({tag, "_valid"}, 64'(m_valid), 64'd1);
    check({tag, "_res"},   64'(m_result), 64'(res));
    check({tag, "_inf"},   64'(m_inf), 64'(inf));
    check({tag, "_zero"},  64'(m_zero), 64'(zero));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int lat;
    int ready_seen;
    int pc0;
    logic [31:0] a9, b9;

    reset   = 1'b1;
    s_valid = 1'b0;
    s_in1   = '0;
    s_in2   = '0;
    m_ready = 1'b1;

    // ---- reset state --------------------------------------------------------
    tick(3);
    s_valid = 1'b1;
    s_in1   = 32'h1234_5678;
    s_in2   = 32'h0bad_f00d;
    @(negedge clk);
    check("rst_s_ready",   64'(s_ready), 64'd0);
    check("rst_add_start", 64'(add_start), 64'd0);
    check("rst_add_in1",   64'(add_in1), 64'd0);
    check("rst_add_in2",   64'(add_in2), 64'd0);
    check("rst_m_valid",   64'(m_valid), 64'd0);
    check("rst_err",       64'(err_unexpected), 64'd0);
    check("rst_state",     64'(dbg_state_o), 64'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    reset   = 1'b0;
    count_flush(n);
    check("flush_len", 64'(n), 64'(LAT + 1));
    check("state_run", 64'(dbg_state_o), 64'd1);

    // ---- single add, minimum latency ---------------------------------------
    hs_cyc.delete();
    pop_cyc.delete();
    s_valid = 1'b1;
    s_in1   = 32'h4000_0000;
    s_in2   = 32'h4000_0000;
    @(negedge clk);
    check("single_start", 64'(add_start), 64'd1);
    check("single_in1",   64'(add_in1), 64'h4000_0000);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("idle_add_in1", 64'(add_in1), 64'd0);
    end while (!m_valid && lat < 50);
    check("single_latency", 64'(lat), 64'(LAT + 1));
    check("single_res",  64'(m_result), 64'h4400_0000);
    check("single_inf",  64'(m_inf), 64'd0);
    check("single_zero", 64'(m_zero), 64'd0);
    @(posedge clk);
    #1;
    wait_drain("single_drain");

    // ---- streaming, 16 back-to-back ----------------------------------------
    hs_cyc.delete();
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) drive_pair($urandom, $urandom);
    wait_drain("stream_drain");
    check("stream_hs",     64'(hs_cyc.size()), 64'd16);
    check("stream_pops",   64'(pop_cyc.size()), 64'd16);
    if (hs_cyc.size() == 16 && pop_cyc.size() == 16) begin
      check("stream_no_stall", 64'(hs_cyc[15] - hs_cyc[0]), 64'd15);
      check("stream_rate",     64'(pop_cyc[15] - pop_cyc[0]), 64'd15);
      check("stream_latency",  64'(pop_cyc[0] - hs_cyc[0]), 64'(LAT + 1));
    end
    check("stream_err", 64'(err_unexpected), 64'd0);

    // ---- backpressure ------------------------------------------------------
    hs_cyc.delete();
    pop_cyc.delete();
    m_ready = 1'b0;
    for (int i = 0; i < DEP; i++) drive_pair($urandom, $urandom);
    a9 = $urandom;
    b9 = $urandom;
    s_valid = 1'b1;
    s_in1   = a9;
    s_in2   = b9;
    ready_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_ready) ready_seen++;
    end
    check("bp_stalled",  64'(ready_seen), 64'd0);
    check("bp_hs_count", 64'(hs_cyc.size()), 64'(DEP));
    check("bp_m_valid",  64'(m_valid), 64'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drive_pair(a9, b9);
    for (int i = 0; i < 3; i++) drive_pair($urandom, $urandom);
    wait_drain("bp_drain");
    check("bp_hs_total",  64'(hs_cyc.size()), 64'(DEP + 4));
    check("bp_pop_total", 64'(pop_cyc.size()), 64'(DEP + 4));
    check("bp_err",       64'(err_unexpected), 64'd0);

    // ---- special values ----------------------------------------------------
    drive_pair(NAR, 32'h4000_0000);
    drive_pair(32'd0, 32'd0);
    expect_out("nar", NAR, 1'b1, 1'b0);
    expect_out("zero", 32'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    wait_drain("special_drain");

    // ---- reset mid-flight --------------------------------------------------
    for (int i = 0; i < 3; i++) drive_pair($urandom, $urandom);
    reset   = 1'b1;
    s_valid = 1'b1;
    s_in1   = 32'h4000_0000;
    s_in2   = 32'h4000_0000;
    @(negedge clk);
    check("mid_rst_s_ready",   64'(s_ready), 64'd0);
    check("mid_rst_add_start", 64'(add_start), 64'd0);
    check("mid_rst_add_in1",   64'(add_in1), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    pc0 = pop_count;
    count_flush(n);
    check("mid_flush_len", 64'(n), 64'(LAT + 1));
    tick(20);
    check("mid_no_results", 64'(pop_count - pc0), 64'd0);
    check("mid_m_valid",    64'(m_valid), 64'd0);

    // ---- protocol error: add_done with nothing issued ----------------------
    inject = 1'b1;
    tick(1);
    inject = 1'b0;
    @(negedge clk);
    check("err_set",     64'(err_unexpected), 64'd1);
    check("err_m_valid", 64'(m_valid), 64'd0);
    tick(5);
    @(negedge clk);
    check("err_sticky",  64'(err_unexpected), 64'd1);
    check("err_no_data", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("err_cleared", 64'(err_unexpected), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/positadd_stream_es3.md
POSITADD_STREAM_ES3 -- requirements
Module: positadd_stream_es3

Interface
REQ-001 The block SHALL be parameterised as follows, one per line: name, default, meaning.
- DEPTH, 8, result FIFO entries; power of two; at least LATENCY+1.
- LATENCY, 4, adder start-to-done latency in cycles.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high. Ports are listed one per line: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- s_valid, in, 1, operand pair valid.
- s_ready, out, 1, operand pair accepted when high with s_valid.
- s_in1, in, 32, posit es3 operand A.
- s_in2, in, 32, posit es3 operand B.
- add_start, out, 1, issue strobe to the es3 posit adder.
- add_in1, out, 32, adder operand A.
- add_in2, out, 32, adder operand B.
- add_result, in, 32, adder sum.
- add_inf, in, 1, adder NaR flag.
- add_zero, in, 1, adder zero flag.
- add_done, in, 1, adder result valid; asserted exactly LATENCY cycles after add_start.
- m_valid, out, 1, result available.
- m_ready, in, 1, downstream accepts the result.
- m_result, out, 32, sum posit.
- m_inf, out, 1, sum is NaR.
- m_zero, out, 1, sum is zero.
- err_unexpected, out, 1, sticky protocol error.

Function
REQ-003 The block SHALL contain a two-state FSM: FLUSH and RUN.
REQ-004 FLUSH SHALL hold a down-counter loaded with LATENCY while reset is high; it decrements each cycle after reset falls and moves to RUN on the cycle after it reaches 0.
REQ-005 s_ready SHALL be high only in RUN and only when the registered (fifo_count + inflight) < DEPTH; m_ready SHALL have no combinational path to s_ready.
REQ-006 add_start SHALL equal s_valid & s_ready, combinationally.
REQ-007 add_in1 and add_in2 SHALL equal s_in1 and s_in2 when add_start is high, and 0 otherwise.
REQ-008 inflight SHALL increment on each issue and decrement on each add_done accepted in RUN; both events in the same cycle SHALL leave it unchanged.
REQ-009 In RUN, add_done SHALL write {add_result, add_inf, add_zero} into the FIFO; a read and a write in the same cycle SHALL both complete, even when the FIFO is full.
REQ-010 In FLUSH, add_done SHALL be ignored and discarded; this covers adder results still in its unreset pipeline.
REQ-011 The FIFO SHALL be show-ahead: m_valid = (fifo_count != 0), and m_result/m_inf/m_zero SHALL come from the head entry.
REQ-012 An entry SHALL pop when m_valid & m_ready.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH; fifo_count SHALL be log2(DEPTH)+1 bits wide.
REQ-014 Results SHALL leave in issue order.
REQ-015 Minimum latency SHALL be: handshake in cycle t gives m_valid in cycle t+LATENCY+1.
REQ-016 Sustained throughput SHALL be 1 operation per cycle while m_ready stays high.
REQ-017 err_unexpected SHALL set, sticky until reset, on either condition:
- add_done in RUN with inflight == 0;
- add_done in RUN with the FIFO full and no pop in that cycle.
In the second case the write SHALL be dropped.

Reset
REQ-018 While reset is high, the block SHALL hold: state FLUSH, counter = LATENCY, inflight = 0, fifo_count = 0, pointers = 0, err_unexpected = 0.
REQ-019 Outputs during reset SHALL be: s_ready = 0, add_start = 0, add_in1/add_in2 = 0, m_valid = 0.
REQ-020 After reset deasserts, s_ready SHALL stay 0 for LATENCY+1 cycles; FIFO contents need no clearing.
REQ-021 Reset asserted mid-operation SHALL drop all queued and in-flight results; none SHALL appear on m_valid afterwards.

Verification
REQ-022 Single add: 0x40000000 + 0x40000000 handshaked in cycle t, m_ready = 1 -> add_start in cycle t; m_valid in cycle t+5; m_result = 0x44000000, m_inf = 0, m_zero = 0.
REQ-023 Streaming: 16 back-to-back pairs with m_ready = 1 -> s_ready never falls; 16 results in order, one per cycle starting at t+5; err_unexpected = 0.
REQ-024 Backpressure: m_ready = 0, s_valid held high -> exactly 8 handshakes, then s_ready = 0. Raising m_ready then drains 8 results in order and the remaining pairs are accepted; err_unexpected = 0.
REQ-025 Special values: 0x80000000 + 0x40000000 -> m_result = 0x80000000, m_inf = 1. 0x00000000 + 0x00000000 -> m_result = 0, m_zero = 1.
REQ-026 Reset mid-flight: issue 3 ops, assert reset for 1 cycle -> m_valid stays 0 thereafter, s_ready = 0 for 5 cycles after reset, then 1.
REQ-027 Protocol error: a stub adder pulses add_done in RUN with nothing issued -> err_unexpected = 1 and stays 1 until reset; m_valid = 0.
